// File: rtl/sma_crossover_order_gen.sv
// SMA crossover order generator: watches fast/slow moving averages, tracks a
// FLAT/LONG/SHORT position with hysteresis, and queues BUY/SELL orders in a FIFO.
module sma_crossover_order_gen #(
    parameter int WARMUP = 4,
    parameter int HYST   = 2,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fast_avg,
    input  logic       fast_valid,
    input  logic [7:0] slow_avg,
    input  logic       slow_valid,
    input  logic       order_ready,
    output logic       order_valid,
    output logic       order_side,
    output logic [7:0] order_price,
    output logic [7:0] order_seq,
    output logic [1:0] position,
    output logic       warm,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       FULL_CNT = DEPTH[AW:0];
    localparam logic [7:0]        WARM_MAX = WARMUP[7:0];
    localparam logic signed [8:0] HYST_P   = HYST[8:0];
    localparam logic signed [8:0] HYST_N   = -HYST_P;

    typedef enum logic [1:0] {
        POS_FLAT  = 2'b00,
        POS_LONG  = 2'b01,
        POS_SHORT = 2'b10
    } pos_t;

    typedef struct packed {
        logic       side;
        logic [7:0] price;
        logic [7:0] seq;
    } order_t;

    pos_t              pos_q;
    pos_t              pos_d;
    logic [7:0]        warm_cnt;
    logic [7:0]        warm_cnt_d;
    logic              warm_q;
    logic [7:0]        seq_q;
    logic [7:0]        drop_q;
    logic signed [8:0] diff;
    logic              accept;
    logic              eval;
    logic              gen;
    logic              gen_side;

    order_t            mem [DEPTH];
    order_t            head;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;

    // A sample pair is only taken when both averages are valid in the same cycle.
    assign accept = fast_valid & slow_valid;
    assign eval   = accept & warm_q;
    assign diff   = $signed({1'b0, fast_avg}) - $signed({1'b0, slow_avg});

    always_comb begin
        warm_cnt_d = warm_cnt;
        if (accept && (warm_cnt != WARM_MAX)) begin
            warm_cnt_d = warm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= 8'd0;
            warm_q   <= 1'b0;
        end else begin
            warm_cnt <= warm_cnt_d;
            warm_q   <= (warm_cnt_d == WARM_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= POS_FLAT;
        end else begin
            pos_q <= pos_d;
        end
    end

    // Dead band |diff| <= HYST holds the position; strict compares make it inclusive.
    always_comb begin
        pos_d    = pos_q;
        gen      = 1'b0;
        gen_side = 1'b0;
        if (eval) begin
            if ((diff > HYST_P) && (pos_q != POS_LONG)) begin
                pos_d    = POS_LONG;
                gen      = 1'b1;
                gen_side = 1'b1;
            end else if ((diff < HYST_N) && (pos_q != POS_SHORT)) begin
                pos_d    = POS_SHORT;
                gen      = 1'b1;
                gen_side = 1'b0;
            end
        end
    end

    // Output handshake: an order transfers on a rising edge where order_valid and
    // order_ready are both 1; the head stays stable until then, and order_ready
    // has no effect while order_valid is 0.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign pop        = !fifo_empty && order_ready;
    assign push       = gen && (!fifo_full || pop);
    assign drop       = gen && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{side: gen_side, price: fast_avg, seq: seq_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            seq_q  <= 8'd0;
            drop_q <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq_q  <= seq_q + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (drop_q != 8'hff)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    // Head fields are masked while empty so reset and idle present zeros.
    assign head        = mem[rd_ptr];
    assign order_valid = !fifo_empty;
    assign order_side  = order_valid & head.side;
    assign order_price = order_valid ? head.price : 8'd0;
    assign order_seq   = order_valid ? head.seq : 8'd0;
    assign position    = pos_q;
    assign warm        = warm_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_sma_crossover_order_gen.sv
// Directed bench for sma_crossover_order_gen: a vector table walked one clock per
// entry, followed by a long backpressure run that drives drop_count to saturation.
module tb_sma_crossover_order_gen;

  logic       clk;
  logic       rst;
  logic [7:0] fast_avg;
  logic       fast_valid;
  logic [7:0] slow_avg;
  logic       slow_valid;
  logic       order_ready;
  logic       order_valid;
  logic       order_side;
  logic [7:0] order_price;
  logic [7:0] order_seq;
  logic [1:0] position;
  logic       warm;
  logic [7:0] drop_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       rst;
    logic       fv;
    logic       sv;
    logic [7:0] fast;
    logic [7:0] slow;
    logic       rdy;
    logic       e_valid;
    logic       e_side;
    logic [7:0] e_price;
    logic [7:0] e_seq;
    logic [1:0] e_pos;
    logic       e_warm;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  sma_crossover_order_gen #(
    .WARMUP(4),
    .HYST(2),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fast_avg(fast_avg),
    .fast_valid(fast_valid),
    .slow_avg(slow_avg),
    .slow_valid(slow_valid),
    .order_ready(order_ready),
    .order_valid(order_valid),
    .order_side(order_side),
    .order_price(order_price),
    .order_seq(order_seq),
    .position(position),
    .warm(warm),
    .drop_count(drop_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic fv, input logic sv,
                              input logic [7:0] f, input logic [7:0] s, input logic rdy,
                              input logic ev, input logic es, input logic [7:0] ep,
                              input logic [7:0] eq, input logic [1:0] epos,
                              input logic ew, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.fv = fv; v.sv = sv; v.fast = f; v.slow = s; v.rdy = rdy;
    v.e_valid = ev; v.e_side = es; v.e_price = ep; v.e_seq = eq;
    v.e_pos = epos; v.e_warm = ew; v.e_drop = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: present one sample, clock it, settle
  task automatic drive(input logic r, input logic fv, input logic sv,
                       input logic [7:0] f, input logic [7:0] s, input logic rdy);
    rst = r; fast_valid = fv; slow_valid = sv;
    fast_avg = f; slow_avg = s; order_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic es,
                           input logic [7:0] ep, input logic [7:0] eq,
                           input logic [1:0] epos, input logic ew, input logic [7:0] ed);
    check({tag, " valid"}, 32'(order_valid), 32'(ev));
    check({tag, " side"}, 32'(order_side), 32'(es));
    check({tag, " price"}, 32'(order_price), 32'(ep));
    check({tag, " seq"}, 32'(order_seq), 32'(eq));
    check({tag, " pos"}, 32'(position), 32'(epos));
    check({tag, " warm"}, 32'(warm), 32'(ew));
    check({tag, " drop"}, 32'(drop_count), 32'(ed));
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; fast_valid = 1'b0; slow_valid = 1'b0;
    fast_avg = 8'd0; slow_avg = 8'd0; order_ready = 1'b0;

    // reset, warm-up with valid gating, first BUY
    tbl.push_back(mk(1, 0, 0,   0,   0, 0,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 120, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 120, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 120, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 150, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 150, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 120, 100, 1,  0, 0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 120, 100, 1,  1, 1, 120, 0, 1, 1, 0));
    // dead band +2, 0, -2 holds LONG; -3 sells
    tbl.push_back(mk(0, 1, 1, 102, 100, 1,  0, 0,   0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 100, 100, 1,  0, 0,   0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,  98, 100, 1,  0, 0,   0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,  97, 100, 0,  1, 0,  97, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 200,   0, 0,  1, 0,  97, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 200,   0, 1,  0, 0,   0, 0, 2, 1, 0));
    // three queued orders then reset mid-run
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  1, 1, 110, 2, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,  90, 100, 0,  1, 1, 110, 2, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  1, 1, 110, 2, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1,  90, 100, 1,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  0, 0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  1, 1, 110, 0, 1, 1, 0));
    // backpressure: fill to 4, two drops, head stable
    tbl.push_back(mk(0, 1, 1,  90, 100, 0,  1, 1, 110, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  1, 1, 110, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1,  90, 100, 0,  1, 1, 110, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 110, 100, 0,  1, 1, 110, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1,  90, 100, 0,  1, 1, 110, 0, 2, 1, 2));
    // full with simultaneous pop, then drain in order
    tbl.push_back(mk(0, 1, 1, 110, 100, 1,  1, 0,  90, 1, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1, 1, 110, 2, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1, 0,  90, 3, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0,   0,   0, 1,  1, 1, 110, 4, 1, 1, 2));
    // single entry: push and pop together
    tbl.push_back(mk(0, 1, 1,  90, 100, 1,  1, 0,  90, 5, 2, 1, 2));
    tbl.push_back(mk(0, 0, 0,   0,   0, 1,  0, 0,   0, 0, 2, 1, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fv, tbl[i].sv, tbl[i].fast, tbl[i].slow, tbl[i].rdy);
      check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_side, tbl[i].e_price,
                tbl[i].e_seq, tbl[i].e_pos, tbl[i].e_warm, tbl[i].e_drop);
    end

    // saturation run: stalled FIFO, alternating crossovers overflow drop_count
    drive(1, 0, 0, 0, 0, 0);
    check_out("sat_rst", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 110, 100, 0);
    check_out("sat_first", 1, 1, 110, 0, 1, 1, 0);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, 1, (i % 2 == 0) ? 8'd90 : 8'd110, 100, 0);
      if (i == 100) check("sat_mid drop", 32'(drop_count), 32'd98);
    end
    check_out("sat_end", 1, 1, 110, 0, 1, 1, 8'd255);

    // drain the four queued orders after saturation
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
    end
    check_out("sat_drain", 0, 0, 0, 0, 1, 1, 8'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
